// File: rtl/rn_pkg.sv
// Shared defaults for the window generator: sample format, channel count and 3x3 tap indices.
package rn_pkg;

  localparam int DATA_W    = 16;
  localparam int FM_DEPTH  = 64;
  localparam int CORE_SIZE = 9;

  // Tap index j = ky*3 + kx inside one 3x3 window
  localparam int TAP_TL = 0;
  localparam int TAP_C  = 4;
  localparam int TAP_BR = 8;

endpackage

// File: rtl/line_buffer.sv
// Single-row delay: dout is the word written DEPTH accepted beats earlier.
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  // Read-before-write at the same slot yields exactly DEPTH beats of delay
  assign dout = r_mem[r_ptr];

  // Circular pointer, advances once per accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (in_valid) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

  // Row storage, no reset needed
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[r_ptr] <= din;
    end
  end

endmodule

// File: rtl/line_window_gen.sv
// Raster-scan 3x3 window generator over a multi-channel pixel stream.
// Two row delays feed a 3-column shift window; only fully-inside windows are emitted.
module line_window_gen #(
  parameter int FM_DEPTH  = rn_pkg::FM_DEPTH,
  parameter int CORE_SIZE = rn_pkg::CORE_SIZE,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int DATA_W    = rn_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic signed [DATA_W-1:0] data_in  [FM_DEPTH],
  output logic signed [DATA_W-1:0] data_out [FM_DEPTH][CORE_SIZE],
  output logic                     data_out_valid,
  output logic                     frame_done
);

  import rn_pkg::*;

  localparam int PIX_W = FM_DEPTH * DATA_W;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    w_col_eff;
  logic [RW-1:0]    w_row_eff;
  logic [CW-1:0]    w_col_nxt;
  logic [RW-1:0]    w_row_nxt;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_emit;

  logic [PIX_W-1:0] w_cur;
  logic [PIX_W-1:0] w_rm1;
  logic [PIX_W-1:0] w_rm2;
  logic [PIX_W-1:0] w_new [3];
  logic [PIX_W-1:0] r_win [3][2];
  logic [PIX_W-1:0] w_tap [3][3];

  for (genvar ch = 0; ch < FM_DEPTH; ch++) begin : g_pack
    assign w_cur[ch*DATA_W +: DATA_W] = data_in[ch];
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_rm1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .din      (w_cur),
    .dout     (w_rm1)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_rm2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .din      (w_rm1),
    .dout     (w_rm2)
  );

  // A start-of-frame beat is treated as pixel (0,0) wherever the counters were
  assign w_col_eff  = in_sof ? '0 : r_col;
  assign w_row_eff  = in_sof ? '0 : r_row;
  assign w_last_col = (w_col_eff == CW'(IMG_W - 1));
  assign w_last_row = (w_row_eff == RW'(IMG_H - 1));
  assign w_col_nxt  = w_last_col ? '0 : w_col_eff + CW'(1);
  assign w_row_nxt  = w_last_col ? (w_last_row ? '0 : w_row_eff + RW'(1)) : w_row_eff;
  assign w_emit     = in_valid && (w_row_eff >= RW'(2)) && (w_col_eff >= CW'(2));

  // Row 0 of the window is the oldest line (r-2), row 2 the current line
  assign w_new[0] = w_rm2;
  assign w_new[1] = w_rm1;
  assign w_new[2] = w_cur;

  for (genvar ky = 0; ky < 3; ky++) begin : g_tap
    assign w_tap[ky][0] = r_win[ky][0];
    assign w_tap[ky][1] = r_win[ky][1];
    assign w_tap[ky][2] = w_new[ky];
  end

  // Position counters and output flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col          <= '0;
      r_row          <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      data_out_valid <= w_emit;
      frame_done     <= w_emit && w_last_row && w_last_col;
      if (in_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
      end
    end
  end

  // Window shift register: columns c-2 and c-1 per row, no reset needed
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int ky = 0; ky < 3; ky++) begin
        r_win[ky][0] <= r_win[ky][1];
        r_win[ky][1] <= w_new[ky];
      end
    end
  end

  // Registered window output, held between emitted windows
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < FM_DEPTH; ch++) begin
        for (int j = 0; j < CORE_SIZE; j++) begin
          data_out[ch][j] <= '0;
        end
      end
    end else if (w_emit) begin
      for (int ch = 0; ch < FM_DEPTH; ch++) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            data_out[ch][TAP_TL + ky*3 + kx] <= w_tap[ky][kx][ch*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen on a 5x4 frame with two channels.
module tb_line_window_gen;
  import rn_pkg::*;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int FD = 2;
  localparam int DW = 16;
  localparam int HAND0 [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] data_in  [FD];
  logic signed [DW-1:0] data_out [FD][CORE_SIZE];
  logic                 data_out_valid;
  logic                 frame_done;

  line_window_gen #(
    .FM_DEPTH(FD), .CORE_SIZE(CORE_SIZE), .IMG_W(W), .IMG_H(H), .DATA_W(DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .frame_done     (frame_done)
  );

  typedef struct {
    int t0 [9];
    int t1 [9];
    bit done;
    bit hand;
    bit last52;
  } exp_t;

  exp_t q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last0 [9];
  int   last1 [9];
  logic rst_q;

  function automatic int pix(input int r, input int c, input int off);
    return 16 * r + c + off;
  endfunction

  function automatic exp_t mk(input int r, input int c, input int off);
    exp_t e;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        e.t0[ky*3+kx] = pix(r - 2 + ky, c - 2 + kx, off);
        e.t1[ky*3+kx] = -pix(r - 2 + ky, c - 2 + kx, off);
      end
    end
    e.done   = (r == H - 1) && (c == W - 1);
    e.hand   = 1'b0;
    e.last52 = 1'b0;
    return e;
  endfunction

  task automatic beat(input bit sof, input int r, input int c, input int off, input bit first_test);
    exp_t e;
    in_valid   = 1'b1;
    in_sof     = sof;
    data_in[0] = 16'(pix(r, c, off));
    data_in[1] = 16'(-pix(r, c, off));
    @(posedge clk);
    if (r >= 2 && c >= 2) begin
      e = mk(r, c, off);
      e.hand   = first_test && (r == 2) && (c == 2);
      e.last52 = first_test && e.done;
      q.push_back(e);
    end
    #1;
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    data_in[0] = 16'sh5A5A;
    data_in[1] = 16'sh7FFF;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int off, input bit gap, input bit sof_first, input bit first_test);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        beat(sof_first && r == 0 && c == 0, r, c, off, first_test);
        if (gap) idle(1);
      end
    end
  endtask

  always @(posedge clk) rst_q <= rst;

  // Monitor: one entry in the queue means a window is due at this sample point
  always @(negedge clk) begin : mon
    exp_t e;
    bit   ev;
    bit   bad;
    ev = (q.size() > 0);
    if (rst_q === 1'b1) begin
      for (int j = 0; j < 9; j++) begin
        last0[j] = 0;
        last1[j] = 0;
      end
    end
    n_tests++;
    if (data_out_valid !== ev) begin
      n_fail++;
      $display("FAIL valid: got %b expected %b at %0t", data_out_valid, ev, $time);
    end
    if (ev) begin
      e = q.pop_front();
      bad = 1'b0;
      for (int j = 0; j < 9; j++) begin
        if (int'(data_out[0][j]) != e.t0[j] || int'(data_out[1][j]) != e.t1[j]) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL window: got ch0 %0d..%0d ch1 %0d..%0d expected ch0 %0d..%0d ch1 %0d..%0d at %0t",
                 data_out[0][0], data_out[0][8], data_out[1][0], data_out[1][8],
                 e.t0[0], e.t0[8], e.t1[0], e.t1[8], $time);
      end
      n_tests++;
      if (frame_done !== e.done) begin
        n_fail++;
        $display("FAIL frame_done: got %b expected %b at %0t", frame_done, e.done, $time);
      end
      if (e.hand) begin
        bad = 1'b0;
        for (int j = 0; j < 9; j++) begin
          if (int'(data_out[0][j]) != HAND0[j] || int'(data_out[1][j]) != -HAND0[j]) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
          n_fail++;
          $display("FAIL first_window: got ch0 tap4 %0d ch1 tap4 %0d expected %0d and %0d",
                   data_out[0][TAP_C], data_out[1][TAP_C], HAND0[TAP_C], -HAND0[TAP_C]);
        end
      end
      if (e.last52) begin
        n_tests++;
        if (int'(data_out[0][TAP_BR]) != 52 || frame_done !== 1'b1) begin
          n_fail++;
          $display("FAIL last_window: got tap8 %0d done %b expected 52 and 1",
                   data_out[0][TAP_BR], frame_done);
        end
      end
      last0 = e.t0;
      last1 = e.t1;
    end else begin
      n_tests++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_done_idle: got %b expected 0 at %0t", frame_done, $time);
      end
      bad = 1'b0;
      for (int j = 0; j < 9; j++) begin
        if (int'(data_out[0][j]) != last0[j] || int'(data_out[1][j]) != last1[j]) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL hold: got ch0 tap0 %0d tap8 %0d expected %0d and %0d at %0t",
                 data_out[0][0], data_out[0][8], last0[0], last0[8], $time);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    data_in[0] = 16'sd0;
    data_in[1] = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous frame, hand-checked first and last windows
    frame(0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // Same frame with a gap after every beat
    frame(0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // Back-to-back frames, second offset by +100
    frame(0, 1'b0, 1'b1, 1'b0);
    frame(100, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Partial frame through (2,2), then restart with in_sof at what would be (2,3)
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!(r == 2 && c > 2)) beat(r == 0 && c == 0, r, c, 300, 1'b0);
      end
    end
    frame(0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Reset after 12 beats, then a frame without in_sof
    for (int k = 0; k < 12; k++) beat(k == 0, k / W, k % W, 400, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame(200, 1'b0, 1'b0, 1'b0);
    idle(3);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d windows outstanding expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
